// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the DRAM port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   REQ_*       : requester index constants (slot numbers on the packed ports)
//   idx_w()     : width of an index into n items (never less than 1 bit)
package dram_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int REQ_ETH0 = 0;
  localparam int REQ_ETH1 = 1;
  localparam int REQ_UART = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each outstanding read so that
// in-order read data can be steered back to it.
//   clk, rst_n          : clock, async active-low reset (FIFO empties)
//   push, push_data     : enqueue a tag (ignored when full)
//   pop                 : dequeue the head tag (ignored when empty)
//   pop_data            : head tag, meaningful only when not empty
//   full, empty, count  : occupancy
module dram_tag_fifo
  import dram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among N_REQ masters.
//   clk, rst_n                       : clock, async active-low reset
//   req_valid/ready/we/last          : per-requester command handshake
//   req_addr, req_wdata              : packed per-requester command fields
//   rsp_valid, rsp_rdata             : one-hot read return, shared data
//   mem_cmd_valid/ready/we/addr/wdata: command toward the SDRAM controller
//   mem_rsp_valid, mem_rsp_rdata     : in-order read data from the controller
//   grant_id, busy, orphan_err       : status (orphan_err is sticky)
//
// state    | meaning
// ST_IDLE  | no owner; pick the next requester round-robin from rr_ptr
// ST_GRANT | owner's beats pass straight through to the controller
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_ready,
  output logic                      mem_cmd_we,
  output logic [ADDR_W-1:0]         mem_cmd_addr,
  output logic [DATA_W-1:0]         mem_cmd_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_rdata,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      orphan_err
);

  localparam int OWN_W  = idx_w(N_REQ);
  localparam int HOLD_W = idx_w(MAX_HOLD);
  localparam int CNT_W  = $clog2(TAG_DEPTH) + 1;

  arb_state_t        state, state_nxt;
  logic [OWN_W-1:0]  owner, owner_nxt;
  logic [OWN_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic              win_found;
  logic [OWN_W-1:0]  win_idx;
  logic [OWN_W-1:0]  cand;
  int                rr_idx;

  logic              own_valid, own_we, own_last;
  logic              stall, accept;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  tag_count;
  logic [OWN_W-1:0]  tag_head;
  logic              tag_push;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      cand = OWN_W'(rr_idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign own_valid = req_valid[owner];
  assign own_we    = req_we[owner];
  assign own_last  = req_last[owner];

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    hold_nxt      = hold;
    stall         = 1'b0;
    accept        = 1'b0;
    req_ready     = '0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          owner_nxt = win_idx;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Only reads need a tag slot; writes always flow.
        stall            = ~own_we & fifo_full;
        mem_cmd_valid    = own_valid & ~stall;
        mem_cmd_we       = own_we;
        mem_cmd_addr     = addr_arr[owner];
        mem_cmd_wdata    = data_arr[owner];
        req_ready[owner] = mem_cmd_ready & ~stall;
        accept           = mem_cmd_valid & mem_cmd_ready;
        if (!own_valid ||
            (accept && (own_last || hold == HOLD_W'(MAX_HOLD - 1)))) begin
          state_nxt  = ST_IDLE;
          hold_nxt   = '0;
          rr_ptr_nxt = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end else if (accept) begin
          hold_nxt = hold + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      hold   <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      hold   <= hold_nxt;
    end
  end

  assign tag_push = accept & ~own_we;

  dram_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (OWN_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (owner),
    .pop       (mem_rsp_valid),
    .pop_data  (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (tag_count)
  );

  // Data is zeroed when nothing is returned so it reads 0 during reset too.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (mem_rsp_valid && !fifo_empty) begin
      rsp_valid[tag_head] = 1'b1;
      rsp_rdata           = mem_rsp_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          orphan_err <= 1'b0;
    else if (mem_rsp_valid && fifo_empty) orphan_err <= 1'b1;
  end

  assign busy     = (state == ST_GRANT) | (tag_count != '0);
  assign grant_id = (state == ST_GRANT) ? owner : '0;

endmodule
